// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial transmitter: takes an operand pair via valid/ready and streams
// it LSB-first as vld/a/b/last bit pairs, with per-word length and hold stalls.
module serial_operand_serializer #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LW-1:0]    in_len,
    input  logic             hold,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LW-1:0] WIDTH_LEN = LW'(WIDTH);
    localparam logic [LW-1:0] ONE_LEN   = LW'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sh_a_reg, sh_a_next;
    logic [WIDTH-1:0] sh_b_reg, sh_b_next;
    logic [LW-1:0]    cnt_reg, cnt_next;
    logic [LW-1:0]    eff_len;
    logic             accept;

    // Out-of-range lengths (0 or above WIDTH) fall back to a full-width word.
    assign eff_len = ((in_len == '0) || (in_len > WIDTH_LEN)) ? WIDTH_LEN : in_len;

    assign busy   = (state_reg == SHIFT);
    assign vld    = busy & ~hold;
    assign a      = vld & sh_a_reg[0];
    assign b      = vld & sh_b_reg[0];
    assign last   = vld & (cnt_reg == ONE_LEN);
    // rst_n gates ready so nothing is offered while reset is asserted.
    assign in_rdy = rst_n & (~busy | last);
    assign accept = in_vld & in_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sh_a_reg  <= '0;
            sh_b_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sh_a_reg  <= sh_a_next;
            sh_b_reg  <= sh_b_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sh_a_next  = sh_a_reg;
        sh_b_next  = sh_b_reg;
        cnt_next   = cnt_reg;
        // Accept wins over emit, so a word taken on the last bit keeps the stream gapless.
        if (accept) begin
            sh_a_next  = in_a;
            sh_b_next  = in_b;
            cnt_next   = eff_len;
            state_next = SHIFT;
        end else if (vld) begin
            sh_a_next = {1'b0, sh_a_reg[WIDTH-1:1]};
            sh_b_next = {1'b0, sh_b_reg[WIDTH-1:1]};
            cnt_next  = cnt_reg - ONE_LEN;
            if (cnt_reg == ONE_LEN) begin
                state_next = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer: logs each cycle's stream, folds bits
// into words through a small serial-adder model, and compares against hand values.
module tb_serial_operand_serializer;

    localparam int WIDTH = 8;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [LW-1:0]    in_len;
    logic             hold;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;
    logic             busy;

    serial_operand_serializer #(.WIDTH(WIDTH), .LW(LW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_len (in_len),
        .hold   (hold),
        .vld    (vld),
        .a      (a),
        .b      (b),
        .last   (last),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ncyc;
    int          pos;
    logic        carry;
    logic [31:0] vld_v, a_v, b_v, last_v, rdy_v, hold_mask;
    logic [31:0] acc_a, acc_b, acc_s;
    logic [31:0] word_a[$];
    logic [31:0] word_b[$];
    logic [31:0] word_s[$];
    logic [7:0]  pa, pb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ncyc = 0;
        pos = 0;
        carry = 1'b0;
        vld_v = '0; a_v = '0; b_v = '0; last_v = '0; rdy_v = '0; hold_mask = '0;
        acc_a = '0; acc_b = '0; acc_s = '0;
        word_a.delete();
        word_b.delete();
        word_s.delete();
    endtask

    // Entered 1 time unit after a rising edge; samples mid-cycle, returns after the next edge.
    task automatic sample_cycle();
        logic s;
        hold = hold_mask[ncyc];
        #2;
        vld_v[ncyc]  = vld;
        a_v[ncyc]    = a;
        b_v[ncyc]    = b;
        last_v[ncyc] = last;
        rdy_v[ncyc]  = in_rdy;
        if (vld) begin
            s = a ^ b ^ carry;
            acc_a[pos] = a;
            acc_b[pos] = b;
            acc_s[pos] = s;
            carry = (a & b) | (a & carry) | (b & carry);
            pos++;
            if (last) begin
                word_a.push_back(acc_a);
                word_b.push_back(acc_b);
                word_s.push_back(acc_s);
                $display("word %0d: a=0x%0h b=0x%0h sum=0x%0h bits=%0d",
                         word_a.size(), acc_a, acc_b, acc_s, pos);
                acc_a = '0; acc_b = '0; acc_s = '0;
                pos = 0;
                carry = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic offer(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vl);
        in_vld = 1'b1;
        in_a   = va;
        in_b   = vb;
        in_len = vl;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0; in_len = '0; hold = 1'b0;
        clear_log();

        // Reset state
        #2;
        check("rst_rdy", {31'd0, in_rdy}, 32'd0);
        check("rst_outs", {27'd0, vld, a, b, last, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_rdy", {31'd0, in_rdy}, 32'd1);
        check("rel_busy", {31'd0, busy}, 32'd0);

        // Basic word, len 0 means full width
        offer(8'h35, 8'h0F, 4'd0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        repeat (8) sample_cycle();
        check("basic_vld", vld_v, 32'h0000_00FF);
        check("basic_a", a_v, 32'h0000_0035);
        check("basic_b", b_v, 32'h0000_000F);
        check("basic_last", last_v, 32'h0000_0080);
        check("basic_sum", word_s[0], 32'h0000_0044);
        check("basic_idle", {31'd0, busy}, 32'd0);

        // Back-to-back words, no bubble
        offer(8'hFF, 8'h01, 4'd0);
        @(posedge clk); #1;
        offer(8'h80, 8'h80, 4'd0);
        clear_log();
        for (int i = 0; i < 16; i++) begin
            sample_cycle();
            if (i == 7) in_vld = 1'b0;
        end
        check("b2b_vld", vld_v, 32'h0000_FFFF);
        check("b2b_last", last_v, 32'h0000_8080);
        check("b2b_rdy", rdy_v, 32'h0000_8080);
        check("b2b_nwords", word_s.size(), 32'd2);
        check("b2b_a0", word_a[0], 32'h0000_00FF);
        check("b2b_a1", word_a[1], 32'h0000_0080);
        check("b2b_sum0", word_s[0], 32'h0000_0000);
        check("b2b_sum1", word_s[1], 32'h0000_0000);

        // Hold on the 3rd bit slot and on the last bit
        offer(8'hA5, 8'h5A, 4'd8);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        hold_mask = 32'h0000_0104;
        repeat (10) sample_cycle();
        hold = 1'b0;
        check("hold_vld", vld_v, 32'h0000_02FB);
        check("hold_ab_gap", (a_v | b_v) & 32'h0000_0104, 32'h0);
        check("hold_last", last_v, 32'h0000_0200);
        check("hold_rdy", rdy_v & 32'h0000_0300, 32'h0000_0200);
        check("hold_a", word_a[0], 32'h0000_00A5);
        check("hold_b", word_b[0], 32'h0000_005A);

        // Short length; sum carry-out of 3 bits is discarded
        offer(8'h07, 8'h01, 4'd3);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        repeat (4) sample_cycle();
        check("short_vld", vld_v, 32'h0000_0007);
        check("short_last", last_v, 32'h0000_0004);
        check("short_sum", word_s[0], 32'h0000_0000);
        check("short_a", word_a[0], 32'h0000_0007);

        // len 9 exceeds WIDTH and acts as 8
        offer(8'hC3, 8'h00, 4'd9);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        repeat (9) sample_cycle();
        check("len9_vld", vld_v, 32'h0000_00FF);
        check("len9_last", last_v, 32'h0000_0080);
        check("len9_a", word_a[0], 32'h0000_00C3);

        // Asynchronous reset in the middle of a word
        offer(8'hFF, 8'hFF, 4'd0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        repeat (3) sample_cycle();
        #2;
        check("pre_rst_vld", {31'd0, vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_outs", {27'd0, vld, a, b, last, busy}, 32'd0);
        check("arst_rdy", {31'd0, in_rdy}, 32'd0);
        @(posedge clk); #1;
        check("arst_hold_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("arst_rel_rdy", {31'd0, in_rdy}, 32'd1);
        offer(8'h01, 8'h01, 4'd0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        clear_log();
        repeat (8) sample_cycle();
        check("post_vld", vld_v, 32'h0000_00FF);
        check("post_last", last_v, 32'h0000_0080);
        check("post_a", word_a[0], 32'h0000_0001);
        check("post_sum", word_s[0], 32'h0000_0002);

        // Stream of single-bit words
        pa = 8'b1011_0010;
        pb = 8'b0110_1001;
        offer({7'd0, pa[0]}, {7'd0, pb[0]}, 4'd1);
        @(posedge clk); #1;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) offer({7'd0, pa[i+1]}, {7'd0, pb[i+1]}, 4'd1);
            else in_vld = 1'b0;
            sample_cycle();
        end
        check("len1_vld", vld_v, 32'h0000_00FF);
        check("len1_last", last_v, 32'h0000_00FF);
        check("len1_rdy", rdy_v, 32'h0000_00FF);
        check("len1_a", a_v, {24'd0, pa});
        check("len1_b", b_v, {24'd0, pb});
        check("len1_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
